trap_sequencer: RTL

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry/return sequencer.
// Picks the next PC source, holds the pipeline flush for a fixed number of
// cycles on trap entry and trap return, pulses the CSR update strobes, and
// latches the trap cause. Every output comes straight from a register, so
// there is no combinational path from any input to any output.
module trap_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    input  logic       mret_in,
    input  logic       eirq_in,
    input  logic       tirq_in,
    input  logic       sirq_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       instr_inc_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       trap_taken_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic [1:0] dbg_state_out
);

    // State encoding matches the PC select code of each state.
    typedef enum logic [1:0] {
        S_BOOT        = 2'b00,
        S_OPERATING   = 2'b01,
        S_TRAP_TAKEN  = 2'b10,
        S_TRAP_RETURN = 2'b11
    } state_t;

    localparam logic [3:0] LP_HOLD = 4'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [1:0] r_pc_src;
    logic       r_flush;
    logic       r_instr_inc;
    logic       r_set_epc;
    logic       r_set_cause;
    logic       r_mie_clear;
    logic       r_mie_set;
    logic       r_trap_taken;
    logic [3:0] r_cause;
    logic       r_i_or_e;

    logic       w_eip;
    logic       w_sip;
    logic       w_tip;
    logic       w_irq;
    logic       w_exc;
    logic       w_trap;
    logic [3:0] w_cause;
    logic       w_i_or_e;

    // Masked interrupt pending terms; a disabled interrupt never traps.
    assign w_eip  = meie_in & eirq_in & mie_in;
    assign w_sip  = msie_in & sirq_in & mie_in;
    assign w_tip  = mtie_in & tirq_in & mie_in;
    assign w_irq  = w_eip | w_sip | w_tip;
    assign w_exc  = illegal_instr_in | misaligned_instr_in |
                    misaligned_load_in | misaligned_store_in;
    assign w_trap = w_irq | w_exc | ecall_in | ebreak_in;

    // Cause priority encoder, highest priority first.
    always_comb begin
        w_cause  = 4'b0000;
        w_i_or_e = 1'b0;
        if (w_eip) begin
            w_cause = 4'b1011; w_i_or_e = 1'b1;
        end else if (w_sip) begin
            w_cause = 4'b0011; w_i_or_e = 1'b1;
        end else if (w_tip) begin
            w_cause = 4'b0111; w_i_or_e = 1'b1;
        end else if (illegal_instr_in) begin
            w_cause = 4'b0010;
        end else if (misaligned_instr_in) begin
            w_cause = 4'b0000;
        end else if (ecall_in) begin
            w_cause = 4'b1011;
        end else if (ebreak_in) begin
            w_cause = 4'b0011;
        end else if (misaligned_store_in) begin
            w_cause = 4'b0110;
        end else if (misaligned_load_in) begin
            w_cause = 4'b0100;
        end
    end

    // Sequencer FSM with hold counter and registered outputs; strobes are
    // set only on the entry edge so they last exactly one cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= S_BOOT;
            r_cnt        <= 4'd0;
            r_pc_src     <= 2'b00;
            r_flush      <= 1'b1;
            r_instr_inc  <= 1'b0;
            r_set_epc    <= 1'b0;
            r_set_cause  <= 1'b0;
            r_mie_clear  <= 1'b0;
            r_mie_set    <= 1'b0;
            r_trap_taken <= 1'b0;
            r_cause      <= 4'b0000;
            r_i_or_e     <= 1'b0;
        end else begin
            r_set_epc    <= 1'b0;
            r_set_cause  <= 1'b0;
            r_mie_clear  <= 1'b0;
            r_mie_set    <= 1'b0;
            r_trap_taken <= 1'b0;
            unique case (r_state)
                S_BOOT: begin
                    r_state     <= S_OPERATING;
                    r_pc_src    <= 2'b01;
                    r_flush     <= 1'b0;
                    r_instr_inc <= 1'b1;
                end
                S_OPERATING: begin
                    if (w_trap) begin
                        r_state      <= S_TRAP_TAKEN;
                        r_cnt        <= LP_HOLD;
                        r_pc_src     <= 2'b10;
                        r_flush      <= 1'b1;
                        r_instr_inc  <= 1'b0;
                        r_set_epc    <= 1'b1;
                        r_set_cause  <= 1'b1;
                        r_mie_clear  <= 1'b1;
                        r_trap_taken <= 1'b1;
                        r_cause      <= w_cause;
                        r_i_or_e     <= w_i_or_e;
                    end else if (mret_in) begin
                        r_state     <= S_TRAP_RETURN;
                        r_cnt       <= LP_HOLD;
                        r_pc_src    <= 2'b11;
                        r_flush     <= 1'b1;
                        r_instr_inc <= 1'b0;
                        r_mie_set   <= 1'b1;
                    end
                end
                S_TRAP_TAKEN, S_TRAP_RETURN: begin
                    // All trap/mret/interrupt inputs are ignored while holding.
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_OPERATING;
                        r_pc_src    <= 2'b01;
                        r_flush     <= 1'b0;
                        r_instr_inc <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end

    assign pc_src_out     = r_pc_src;
    assign flush_out      = r_flush;
    assign instr_inc_out  = r_instr_inc;
    assign set_epc_out    = r_set_epc;
    assign set_cause_out  = r_set_cause;
    assign mie_clear_out  = r_mie_clear;
    assign mie_set_out    = r_mie_set;
    assign trap_taken_out = r_trap_taken;
    assign cause_out      = r_cause;
    assign i_or_e_out     = r_i_or_e;
    assign dbg_state_out  = r_state;

endmodule
